stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Parametrised successor to the team's stopwatch datapath.
- Contains four parts:
  - a clock prescaler;
  - a min:sec counter that can count up, or count down from a preset (countdown with alarm);
  - an opcode-driven control FSM;
  - a LAP_DEPTH-entry lap-capture FIFO.
- Sits between the board clock and the BINARY_TO_BCD/hexa display chain; sec/min stay 8-bit binary so they feed the converters unchanged.

Parameters:
- TICK_DIV, 50000000: clk cycles per one-second tick; must be >= 2.
- MAX_MIN, 99: highest minute value; must be <= 255.
- LAP_DEPTH, 8: lap FIFO entries; must be a power of 2.
- LAP_AW, 3: log2(LAP_DEPTH).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_b  in  1  asynchronous reset, active-high; the port keeps the codebase name but asserts on 1.
- op_valid  in  1  qualifies operation for one cycle.
- operation  in  3  opcodes: 000 NOP, 001 START, 010 STOP, 011 CLEAR, 100 LAP, 101 LOAD, 110 MODE_UP, 111 MODE_DOWN.
- preset_min  in  8  minute value used by LOAD.
- preset_sec  in  8  second value used by LOAD.
- sec  out  8  current seconds, 0..59.
- min  out  8  current minutes, 0..MAX_MIN.
- running  out  1  high in RUN.
- down_mode  out  1  0 = count up, 1 = count down.
- expired  out  1  high in EXPIRED.
- alarm  out  1  one-cycle pulse on wrap (up mode) or on reaching 00:00 (down mode).
- saved_operation  out  3  last accepted, non-ignored opcode.
- lap_rd  in  1  pop head of the lap FIFO.
- lap_min  out  8  minutes of the FIFO head (show-ahead).
- lap_sec  out  8  seconds of the FIFO head (show-ahead).
- lap_empty  out  1  FIFO is empty.
- lap_full  out  1  FIFO is full.
- lap_count  out  LAP_AW+1  number of stored laps.
- lap_ovf  out  1  sticky: a LAP was dropped because the FIFO was full.

Behaviour:
- Reset (rst_b=1, async):
  - state IDLE; sec=min=0; prescaler=0; down_mode=0.
  - running=expired=alarm=0; saved_operation=000.
  - FIFO empty (lap_count=0, lap_empty=1, lap_full=0); lap_ovf=0; lap_min=lap_sec=0.
- Reset mid-count discards time, laps and mode immediately, without waiting for a clock edge.
- FSM states: IDLE, RUN, PAUSED, EXPIRED. Ops are acted on only when op_valid=1.
  - START: IDLE/PAUSED -> RUN. Ignored if down_mode=1 and time is 00:00.
  - STOP: RUN -> PAUSED.
  - CLEAR: any state -> IDLE; time 00:00; prescaler 0; FIFO flushed; lap_ovf cleared.
  - LAP: in RUN/PAUSED, push {min,sec} into the FIFO.
  - LOAD: in IDLE/PAUSED/EXPIRED.
    - Time <= preset, with sec clamped to 59 and min clamped to MAX_MIN.
    - Prescaler 0; next state IDLE.
  - MODE_UP / MODE_DOWN: in IDLE/PAUSED, set down_mode. Ignored in RUN/EXPIRED.
  - Any op not legal in the current state is ignored and leaves saved_operation unchanged.
- Prescaler:
  - Counts only in RUN; holds its value in PAUSED, so fractional seconds are preserved.
  - tick = (prescaler == TICK_DIV-1) while in RUN; on a tick the prescaler returns to 0.
  - First time update lands TICK_DIV clock edges after the START edge.
- Up count, on each tick:
  - sec++ ; at 59, sec -> 0 and min++.
  - MAX_MIN:59 -> 00:00 with alarm pulse; state stays RUN.
- Down count, on each tick:
  - sec-- ; at 0 with min > 0, sec -> 59 and min--.
  - 00:01 -> 00:00: alarm pulses in the same cycle time becomes 00:00; state -> EXPIRED.
  - EXPIRED holds 00:00 until CLEAR or LOAD.
- Op arriving on a tick cycle:
  - CLEAR and LOAD override the tick.
  - STOP: the tick is applied, then the state becomes PAUSED.
  - LAP: captures the pre-tick time (the registered value).
- Lap FIFO:
  - Show-ahead: lap_min/lap_sec always present the head entry; they read 0 when empty.
  - lap_rd while empty is ignored.
  - LAP while full and no lap_rd: entry dropped, lap_ovf set.
  - LAP + lap_rd in the same cycle when full: pop and push both occur; count unchanged.
  - LAP + lap_rd in the same cycle when empty: pushed only.
  - Pointers wrap modulo LAP_DEPTH; lap_count reaches exactly LAP_DEPTH when full.
- All outputs are registered; there are no combinational paths from inputs to outputs except the show-ahead head data.

Test Plan:
Bench parameters: TICK_DIV=4, MAX_MIN=2, LAP_DEPTH=4.
- Reset, START, run 12 clk -> sec=3, min=0. STOP, wait 20 clk -> time holds at 00:03. START -> 00:04 lands exactly 4 clk after the restart edge (prescaler was 0 at STOP).
- Up-count wrap: LOAD 02:58, START, run 8 clk -> time 00:00, alarm high for exactly 1 cycle, running=1.
- Countdown: MODE_DOWN, LOAD 00:02, START, run 8 clk -> 00:00, alarm pulse, expired=1. Then START -> ignored (saved_operation stays 001). LOAD 00:05 -> IDLE.
- Preset clamp: LOAD with preset_min=7, preset_sec=75 -> time 02:59.
- Lap FIFO fill and overflow: in RUN, issue 5 LAP ops -> lap_full=1, lap_count=4, lap_ovf=1. 4× lap_rd -> entries come out in capture order, then lap_empty=1. A further lap_rd leaves lap_count=0.
- Simultaneous events and async reset:
  - LAP on a tick cycle at 00:03 -> stored 00:03 while time becomes 00:04.
  - LAP+lap_rd when full -> lap_count stays 4.
  - rst_b pulse mid-RUN between edges -> all outputs zero immediately.

Source files
------------

// File: rtl/stopwatch_core.sv
// Stopwatch datapath: prescaler, up/down min:sec counter with alarm, opcode FSM
// and a show-ahead lap-capture FIFO. sec/min are plain 8-bit binary.
module stopwatch_core #(
    parameter int TICK_DIV  = 50000000,
    parameter int MAX_MIN   = 99,
    parameter int LAP_DEPTH = 8,
    parameter int LAP_AW    = 3
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              op_valid,
    input  logic [2:0]        operation,
    input  logic [7:0]        preset_min,
    input  logic [7:0]        preset_sec,
    output logic [7:0]        sec,
    output logic [7:0]        min,
    output logic              running,
    output logic              down_mode,
    output logic              expired,
    output logic              alarm,
    output logic [2:0]        saved_operation,
    input  logic              lap_rd,
    output logic [7:0]        lap_min,
    output logic [7:0]        lap_sec,
    output logic              lap_empty,
    output logic              lap_full,
    output logic [LAP_AW:0]   lap_count,
    output logic              lap_ovf
);

    localparam int              PW           = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST   = PW'(TICK_DIV - 1);
    localparam logic [7:0]      MAX_MIN_V    = 8'(MAX_MIN);
    localparam logic [LAP_AW:0] LAP_FULL_CNT = (LAP_AW + 1)'(LAP_DEPTH);

    localparam logic [2:0] OP_START     = 3'b001;
    localparam logic [2:0] OP_STOP      = 3'b010;
    localparam logic [2:0] OP_CLEAR     = 3'b011;
    localparam logic [2:0] OP_LAP       = 3'b100;
    localparam logic [2:0] OP_LOAD      = 3'b101;
    localparam logic [2:0] OP_MODE_UP   = 3'b110;
    localparam logic [2:0] OP_MODE_DOWN = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_sec;
    logic [7:0]    r_min;
    logic          r_down;
    logic          r_running;
    logic          r_expired;
    logic          r_alarm;
    logic [2:0]    r_saved;

    logic [LAP_AW-1:0] r_wr_ptr;
    logic [LAP_AW-1:0] r_rd_ptr;
    logic [LAP_AW:0]   r_count;
    logic              r_ovf;
    logic [15:0]       r_lap_mem [LAP_DEPTH];

    logic   w_time_zero;
    logic   w_tick;
    logic   w_start_ok;
    logic   w_stop_ok;
    logic   w_clear_ok;
    logic   w_lap_ok;
    logic   w_load_ok;
    logic   w_mode_ok;
    logic   w_accept;
    logic   w_full;
    logic   w_pop;
    logic   w_push;
    logic [7:0] w_load_sec;
    logic [7:0] w_load_min;
    logic [7:0] w_sec_cnt;
    logic [7:0] w_min_cnt;
    logic   w_cnt_alarm;
    logic   w_cnt_expire;
    state_t w_state_next;
    logic [15:0] w_head;

    assign w_time_zero = (r_sec == 8'd0) && (r_min == 8'd0);
    assign w_tick      = (r_state == S_RUN) && (r_presc == PRESC_LAST);

    assign w_start_ok = op_valid && (operation == OP_START)
                        && ((r_state == S_IDLE) || (r_state == S_PAUSED))
                        && !(r_down && w_time_zero);
    assign w_stop_ok  = op_valid && (operation == OP_STOP) && (r_state == S_RUN);
    assign w_clear_ok = op_valid && (operation == OP_CLEAR);
    assign w_lap_ok   = op_valid && (operation == OP_LAP)
                        && ((r_state == S_RUN) || (r_state == S_PAUSED));
    assign w_load_ok  = op_valid && (operation == OP_LOAD) && (r_state != S_RUN);
    assign w_mode_ok  = op_valid
                        && ((operation == OP_MODE_UP) || (operation == OP_MODE_DOWN))
                        && ((r_state == S_IDLE) || (r_state == S_PAUSED));
    assign w_accept   = w_start_ok || w_stop_ok || w_clear_ok || w_lap_ok
                        || w_load_ok || w_mode_ok;

    assign w_load_sec = (preset_sec > 8'd59) ? 8'd59 : preset_sec;
    assign w_load_min = (preset_min > MAX_MIN_V) ? MAX_MIN_V : preset_min;

    // Time value one tick later, in the current direction.
    always_comb begin
        w_sec_cnt    = r_sec;
        w_min_cnt    = r_min;
        w_cnt_alarm  = 1'b0;
        w_cnt_expire = 1'b0;
        if (!r_down) begin
            if (r_sec >= 8'd59) begin
                w_sec_cnt = 8'd0;
                if (r_min >= MAX_MIN_V) begin
                    w_min_cnt   = 8'd0;
                    w_cnt_alarm = 1'b1;
                end else begin
                    w_min_cnt = r_min + 8'd1;
                end
            end else begin
                w_sec_cnt = r_sec + 8'd1;
            end
        end else begin
            if (r_sec != 8'd0) begin
                w_sec_cnt = r_sec - 8'd1;
                if ((r_sec == 8'd1) && (r_min == 8'd0)) begin
                    w_cnt_alarm  = 1'b1;
                    w_cnt_expire = 1'b1;
                end
            end else if (r_min != 8'd0) begin
                w_sec_cnt = 8'd59;
                w_min_cnt = r_min - 8'd1;
            end
        end
    end

    // STOP on a tick cycle still lets the tick land; only the state changes.
    always_comb begin
        w_state_next = r_state;
        if (w_clear_ok || w_load_ok) begin
            w_state_next = S_IDLE;
        end else if (w_start_ok) begin
            w_state_next = S_RUN;
        end else if (w_stop_ok) begin
            w_state_next = S_PAUSED;
        end else if (w_tick && w_cnt_expire) begin
            w_state_next = S_EXPIRED;
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_sec     <= 8'd0;
            r_min     <= 8'd0;
            r_down    <= 1'b0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_alarm   <= 1'b0;
            r_saved   <= 3'b000;
        end else begin
            r_state   <= w_state_next;
            r_running <= (w_state_next == S_RUN);
            r_expired <= (w_state_next == S_EXPIRED);
            r_alarm   <= 1'b0;
            if (w_accept) begin
                r_saved <= operation;
            end
            if (w_mode_ok) begin
                r_down <= (operation == OP_MODE_DOWN);
            end
            if (w_clear_ok) begin
                r_sec   <= 8'd0;
                r_min   <= 8'd0;
                r_presc <= '0;
            end else if (w_load_ok) begin
                r_sec   <= w_load_sec;
                r_min   <= w_load_min;
                r_presc <= '0;
            end else if (r_state == S_RUN) begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_sec   <= w_sec_cnt;
                    r_min   <= w_min_cnt;
                    r_alarm <= w_cnt_alarm;
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
        end
    end

    // A full FIFO still accepts a lap when a pop frees a slot in the same cycle.
    assign w_full = (r_count == LAP_FULL_CNT);
    assign w_pop  = lap_rd && (r_count != '0);
    assign w_push = w_lap_ok && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (w_clear_ok) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LAP_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LAP_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (LAP_AW + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (LAP_AW + 1)'(1);
            end
            if (w_lap_ok && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_lap_mem[r_wr_ptr] <= {r_min, r_sec};
        end
    end

    assign w_head = r_lap_mem[r_rd_ptr];

    assign sec             = r_sec;
    assign min             = r_min;
    assign running         = r_running;
    assign down_mode       = r_down;
    assign expired         = r_expired;
    assign alarm           = r_alarm;
    assign saved_operation = r_saved;
    assign lap_empty       = (r_count == '0);
    assign lap_full        = w_full;
    assign lap_count       = r_count;
    assign lap_ovf         = r_ovf;
    assign lap_min         = lap_empty ? 8'd0 : w_head[15:8];
    assign lap_sec         = lap_empty ? 8'd0 : w_head[7:0];

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: table-driven opcode vectors plus
// hand-written sequences for alarm pulses, lap FIFO corners and async reset.
module tb_stopwatch_core;

    localparam logic [2:0] OP_NOP       = 3'b000;
    localparam logic [2:0] OP_START     = 3'b001;
    localparam logic [2:0] OP_STOP      = 3'b010;
    localparam logic [2:0] OP_CLEAR     = 3'b011;
    localparam logic [2:0] OP_LAP       = 3'b100;
    localparam logic [2:0] OP_LOAD      = 3'b101;
    localparam logic [2:0] OP_MODE_UP   = 3'b110;
    localparam logic [2:0] OP_MODE_DOWN = 3'b111;

    logic       clk;
    logic       rst_b;
    logic       op_valid;
    logic [2:0] operation;
    logic [7:0] preset_min;
    logic [7:0] preset_sec;
    logic [7:0] sec;
    logic [7:0] min;
    logic       running;
    logic       down_mode;
    logic       expired;
    logic       alarm;
    logic [2:0] saved_operation;
    logic       lap_rd;
    logic [7:0] lap_min;
    logic [7:0] lap_sec;
    logic       lap_empty;
    logic       lap_full;
    logic [2:0] lap_count;
    logic       lap_ovf;

    int checks = 0;
    int errors = 0;

    stopwatch_core #(
        .TICK_DIV (4),
        .MAX_MIN  (2),
        .LAP_DEPTH(4),
        .LAP_AW   (2)
    ) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .op_valid       (op_valid),
        .operation      (operation),
        .preset_min     (preset_min),
        .preset_sec     (preset_sec),
        .sec            (sec),
        .min            (min),
        .running        (running),
        .down_mode      (down_mode),
        .expired        (expired),
        .alarm          (alarm),
        .saved_operation(saved_operation),
        .lap_rd         (lap_rd),
        .lap_min        (lap_min),
        .lap_sec        (lap_sec),
        .lap_empty      (lap_empty),
        .lap_full       (lap_full),
        .lap_count      (lap_count),
        .lap_ovf        (lap_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] pmin;
        logic [7:0] psec;
        int         wait_cyc;
        logic [7:0] e_min;
        logic [7:0] e_sec;
        logic       e_run;
        logic       e_down;
        logic       e_exp;
        logic [2:0] e_saved;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] pm, input logic [7:0] ps,
                                input int w, input logic [7:0] em, input logic [7:0] es,
                                input logic r, input logic d, input logic x, input logic [2:0] sv);
        vec_t v;
        v.op = op; v.pmin = pm; v.psec = ps; v.wait_cyc = w;
        v.e_min = em; v.e_sec = es; v.e_run = r; v.e_down = d; v.e_exp = x; v.e_saved = sv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [7:0] pm, input logic [7:0] ps);
        op_valid   = 1'b1;
        operation  = op;
        preset_min = pm;
        preset_sec = ps;
        cyc(1);
        op_valid   = 1'b0;
        operation  = OP_NOP;
    endtask

    task automatic run_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            do_op(vecs[i].op, vecs[i].pmin, vecs[i].psec);
            cyc(vecs[i].wait_cyc);
            $display("vec %0d op=%0d -> %0d:%0d run=%0d down=%0d exp=%0d saved=%0d",
                     i, vecs[i].op, min, sec, running, down_mode, expired, saved_operation);
            check($sformatf("v%0d_min", i), 32'(min), 32'(vecs[i].e_min));
            check($sformatf("v%0d_sec", i), 32'(sec), 32'(vecs[i].e_sec));
            check($sformatf("v%0d_running", i), 32'(running), 32'(vecs[i].e_run));
            check($sformatf("v%0d_down", i), 32'(down_mode), 32'(vecs[i].e_down));
            check($sformatf("v%0d_expired", i), 32'(expired), 32'(vecs[i].e_exp));
            check($sformatf("v%0d_saved", i), 32'(saved_operation), 32'(vecs[i].e_saved));
        end
    endtask

    initial begin
        int pulses;

        vecs[0]  = mk(OP_START,     8'd0, 8'd0,  11, 8'd0, 8'd2,  1'b1, 1'b0, 1'b0, OP_START);
        vecs[1]  = mk(OP_STOP,      8'd0, 8'd0,  0,  8'd0, 8'd3,  1'b0, 1'b0, 1'b0, OP_STOP);
        vecs[2]  = mk(OP_NOP,       8'd0, 8'd0,  20, 8'd0, 8'd3,  1'b0, 1'b0, 1'b0, OP_STOP);
        vecs[3]  = mk(OP_START,     8'd0, 8'd0,  3,  8'd0, 8'd3,  1'b1, 1'b0, 1'b0, OP_START);
        vecs[4]  = mk(OP_NOP,       8'd0, 8'd0,  0,  8'd0, 8'd4,  1'b1, 1'b0, 1'b0, OP_START);
        vecs[5]  = mk(OP_STOP,      8'd0, 8'd0,  0,  8'd0, 8'd4,  1'b0, 1'b0, 1'b0, OP_STOP);
        vecs[6]  = mk(OP_LOAD,      8'd2, 8'd58, 0,  8'd2, 8'd58, 1'b0, 1'b0, 1'b0, OP_LOAD);
        vecs[7]  = mk(OP_STOP,      8'd0, 8'd0,  0,  8'd0, 8'd0,  1'b0, 1'b0, 1'b0, OP_STOP);
        vecs[8]  = mk(OP_MODE_DOWN, 8'd0, 8'd0,  0,  8'd0, 8'd0,  1'b0, 1'b1, 1'b0, OP_MODE_DOWN);
        vecs[9]  = mk(OP_LOAD,      8'd0, 8'd2,  0,  8'd0, 8'd2,  1'b0, 1'b1, 1'b0, OP_LOAD);
        vecs[10] = mk(OP_START,     8'd0, 8'd0,  0,  8'd0, 8'd0,  1'b0, 1'b1, 1'b1, OP_START);
        vecs[11] = mk(OP_LOAD,      8'd0, 8'd5,  0,  8'd0, 8'd5,  1'b0, 1'b1, 1'b0, OP_LOAD);
        vecs[12] = mk(OP_LOAD,      8'd7, 8'd75, 0,  8'd2, 8'd59, 1'b0, 1'b1, 1'b0, OP_LOAD);
        vecs[13] = mk(OP_MODE_UP,   8'd0, 8'd0,  0,  8'd2, 8'd59, 1'b0, 1'b0, 1'b0, OP_MODE_UP);
        vecs[14] = mk(OP_CLEAR,     8'd0, 8'd0,  0,  8'd0, 8'd0,  1'b0, 1'b0, 1'b0, OP_CLEAR);

        rst_b      = 1'b1;
        op_valid   = 1'b0;
        operation  = OP_NOP;
        preset_min = 8'd0;
        preset_sec = 8'd0;
        lap_rd     = 1'b0;
        cyc(3);
        rst_b = 1'b0;
        $display("reset released");
        check("rst_sec", 32'(sec), 32'd0);
        check("rst_min", 32'(min), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_saved", 32'(saved_operation), 32'd0);
        check("rst_lap_count", 32'(lap_count), 32'd0);
        check("rst_lap_empty", 32'(lap_empty), 32'd1);
        check("rst_lap_full", 32'(lap_full), 32'd0);
        check("rst_lap_ovf", 32'(lap_ovf), 32'd0);
        cyc(1);

        run_vecs(0, 6);

        // Up-count wrap from 02:58 with MAX_MIN=2: 02:59 at edge 4, 00:00 at edge 8.
        do_op(OP_START, 8'd0, 8'd0);
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1);
            if (alarm) pulses++;
            if (i == 4) check("wrap_sec_59", 32'(sec), 32'd59);
            if (i == 8) begin
                check("wrap_min", 32'(min), 32'd0);
                check("wrap_sec", 32'(sec), 32'd0);
                check("wrap_alarm", 32'(alarm), 32'd1);
                check("wrap_running", 32'(running), 32'd1);
            end
        end
        $display("up wrap: alarm pulses=%0d", pulses);
        check("wrap_alarm_pulses", 32'(pulses), 32'd1);

        run_vecs(7, 9);

        // Countdown 00:02 -> 00:01 at edge 4 -> 00:00 + alarm + EXPIRED at edge 8.
        do_op(OP_START, 8'd0, 8'd0);
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1);
            if (alarm) pulses++;
            if (i == 4) check("down_sec_1", 32'(sec), 32'd1);
            if (i == 8) begin
                check("down_sec_0", 32'(sec), 32'd0);
                check("down_alarm", 32'(alarm), 32'd1);
                check("down_expired", 32'(expired), 32'd1);
                check("down_running", 32'(running), 32'd0);
            end
        end
        $display("countdown: alarm pulses=%0d", pulses);
        check("down_alarm_pulses", 32'(pulses), 32'd1);

        run_vecs(10, 14);

        // Lap FIFO fill: laps at 00:00..00:03, fifth lap dropped.
        do_op(OP_START, 8'd0, 8'd0);
        for (int k = 0; k < 5; k++) begin
            do_op(OP_LAP, 8'd0, 8'd0);
            $display("lap %0d count=%0d full=%0d ovf=%0d", k, lap_count, lap_full, lap_ovf);
            if (k < 4) cyc(3);
        end
        check("fill_full", 32'(lap_full), 32'd1);
        check("fill_count", 32'(lap_count), 32'd4);
        check("fill_ovf", 32'(lap_ovf), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pop%0d_min", k), 32'(lap_min), 32'd0);
            check($sformatf("pop%0d_sec", k), 32'(lap_sec), 32'(k));
            lap_rd = 1'b1;
            cyc(1);
            lap_rd = 1'b0;
            $display("pop %0d count=%0d", k, lap_count);
        end
        check("drain_empty", 32'(lap_empty), 32'd1);
        check("drain_count", 32'(lap_count), 32'd0);
        check("drain_head_sec", 32'(lap_sec), 32'd0);
        lap_rd = 1'b1;
        cyc(1);
        lap_rd = 1'b0;
        check("extra_rd_count", 32'(lap_count), 32'd0);
        check("extra_rd_empty", 32'(lap_empty), 32'd1);
        check("extra_rd_ovf", 32'(lap_ovf), 32'd1);

        do_op(OP_CLEAR, 8'd0, 8'd0);
        check("clear_ovf", 32'(lap_ovf), 32'd0);

        // LAP on the tick that moves 00:03 to 00:04 captures 00:03.
        do_op(OP_START, 8'd0, 8'd0);
        cyc(15);
        do_op(OP_LAP, 8'd0, 8'd0);
        $display("tick lap: time %0d:%0d head %0d:%0d", min, sec, lap_min, lap_sec);
        check("ticklap_time_sec", 32'(sec), 32'd4);
        check("ticklap_head_sec", 32'(lap_sec), 32'd3);
        check("ticklap_count", 32'(lap_count), 32'd1);
        for (int k = 0; k < 3; k++) do_op(OP_LAP, 8'd0, 8'd0);
        check("refill_full", 32'(lap_full), 32'd1);
        lap_rd = 1'b1;
        do_op(OP_LAP, 8'd0, 8'd0);
        lap_rd = 1'b0;
        $display("lap+rd when full: count=%0d head %0d:%0d", lap_count, lap_min, lap_sec);
        check("lap_rd_full_count", 32'(lap_count), 32'd4);
        check("lap_rd_full_ovf", 32'(lap_ovf), 32'd0);
        check("lap_rd_full_head", 32'(lap_sec), 32'd4);
        check("lap_rd_full_time", 32'(sec), 32'd5);

        // Asynchronous reset between clock edges.
        #2;
        rst_b = 1'b1;
        #1;
        $display("async reset: time %0d:%0d run=%0d count=%0d", min, sec, running, lap_count);
        check("arst_sec", 32'(sec), 32'd0);
        check("arst_running", 32'(running), 32'd0);
        check("arst_count", 32'(lap_count), 32'd0);
        check("arst_full", 32'(lap_full), 32'd0);
        check("arst_saved", 32'(saved_operation), 32'd0);
        #1;
        rst_b = 1'b0;
        cyc(6);
        check("post_rst_sec", 32'(sec), 32'd0);
        check("post_rst_running", 32'(running), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
